// File: rtl/zxuno_port_bridge.sv
// ZXUNO register-port bridge: decodes Z80 I/O cycles on the address and data ports,
// filters short glitches, and drives the internal register-block handshake and CPU read data.
module zxuno_port_bridge #(
  parameter logic [15:0] IOADDR = 16'hFC3B,
  parameter logic [15:0] IODATA = 16'hFD3B,
  parameter int          MINLEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  reg_rddata,
  input  logic        reg_oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wrdata,
  output logic [7:0]  dout,
  output logic        oe_n
);

  typedef enum logic [2:0] {IDLE, FILT, WA, WD, RA, RD} state_t;

  localparam logic [1:0] K_WA = 2'd0;
  localparam logic [1:0] K_WD = 2'd1;
  localparam logic [1:0] K_RA = 2'd2;
  localparam logic [1:0] K_RD = 2'd3;
  localparam logic [2:0] MINLEN_C = 3'(MINLEN);

  logic [15:0] a_reg;
  logic        iorq_n_reg, m1_n_reg, rd_n_reg, wr_n_reg;
  logic [7:0]  cpu_dout_reg;

  state_t      state_reg, state_next;
  logic [1:0]  kind_reg, kind_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  hold_reg, hold_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  wrdata_reg, wrdata_next;
  logic        regwr_reg, regwr_next;
  logic        regrd_reg, regrd_next;
  logic [7:0]  dout_reg, dout_next;
  logic        oe_n_reg, oe_n_next;

  logic q_wa, q_wd, q_ra, q_rd, any_q, q_sel;
  logic [1:0] cur_kind;

  // Interrupt acknowledge (M1 low) can never qualify.
  logic io_cycle;
  assign io_cycle = ~iorq_n_reg & m1_n_reg;
  assign q_wa  = io_cycle & ~wr_n_reg & (a_reg == IOADDR);
  assign q_wd  = io_cycle & ~wr_n_reg & (a_reg == IODATA);
  assign q_ra  = io_cycle & ~rd_n_reg & (a_reg == IOADDR);
  assign q_rd  = io_cycle & ~rd_n_reg & (a_reg == IODATA);
  assign any_q = q_wa | q_wd | q_ra | q_rd;

  always_comb begin
    cur_kind = K_RD;
    if (q_wa)      cur_kind = K_WA;
    else if (q_wd) cur_kind = K_WD;
    else if (q_ra) cur_kind = K_RA;
  end

  always_comb begin
    case (kind_reg)
      K_WA:    q_sel = q_wa;
      K_WD:    q_sel = q_wd;
      K_RA:    q_sel = q_ra;
      default: q_sel = q_rd;
    endcase
  end

  function automatic state_t access_state(input logic [1:0] k);
    case (k)
      K_WA:    return WA;
      K_WD:    return WD;
      K_RA:    return RA;
      default: return RD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= 16'h0000;
      iorq_n_reg   <= 1'b1;
      m1_n_reg     <= 1'b1;
      rd_n_reg     <= 1'b1;
      wr_n_reg     <= 1'b1;
      cpu_dout_reg <= 8'h00;
    end else begin
      a_reg        <= a;
      iorq_n_reg   <= iorq_n;
      m1_n_reg     <= m1_n;
      rd_n_reg     <= rd_n;
      wr_n_reg     <= wr_n;
      cpu_dout_reg <= cpu_dout;
    end
  end

  always_comb begin
    state_next  = state_reg;
    kind_next   = kind_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    wrdata_next = wrdata_reg;
    regwr_next  = 1'b0;
    // Tracks the most recent write data seen while a write qualifier is active.
    hold_next   = (q_wa | q_wd) ? cpu_dout_reg : hold_reg;

    case (state_reg)
      IDLE: begin
        if (any_q) begin
          kind_next  = cur_kind;
          cnt_next   = 3'd1;
          state_next = (MINLEN_C <= 3'd1) ? access_state(cur_kind) : FILT;
        end
      end
      FILT: begin
        if (q_sel) begin
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg + 3'd1 >= MINLEN_C) state_next = access_state(kind_reg);
        end else begin
          cnt_next   = 3'd0;
          state_next = IDLE;
        end
      end
      WA: begin
        if (!q_sel) begin
          addr_next  = hold_reg;
          cnt_next   = 3'd0;
          state_next = IDLE;
        end
      end
      WD: begin
        if (!q_sel) begin
          wrdata_next = hold_reg;
          regwr_next  = 1'b1;
          cnt_next    = 3'd0;
          state_next  = IDLE;
        end
      end
      RA, RD: begin
        if (!q_sel) begin
          cnt_next   = 3'd0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = 3'd0;
        state_next = IDLE;
      end
    endcase

    regrd_next = (state_next == RD);

    // Bus drive lags the read states by one clock so reg_rddata has settled under regrd.
    oe_n_next = 1'b1;
    dout_next = dout_reg;
    if (state_reg == RA) begin
      oe_n_next = 1'b0;
      dout_next = addr_reg;
    end else if (state_reg == RD) begin
      oe_n_next = reg_oe_n;
      dout_next = reg_rddata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      kind_reg   <= K_WA;
      cnt_reg    <= 3'd0;
      hold_reg   <= 8'h00;
      addr_reg   <= 8'h00;
      wrdata_reg <= 8'h00;
      regwr_reg  <= 1'b0;
      regrd_reg  <= 1'b0;
      dout_reg   <= 8'h00;
      oe_n_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      kind_reg   <= kind_next;
      cnt_reg    <= cnt_next;
      hold_reg   <= hold_next;
      addr_reg   <= addr_next;
      wrdata_reg <= wrdata_next;
      regwr_reg  <= regwr_next;
      regrd_reg  <= regrd_next;
      dout_reg   <= dout_next;
      oe_n_reg   <= oe_n_next;
    end
  end

  assign zxuno_addr   = addr_reg;
  assign zxuno_regrd  = regrd_reg;
  assign zxuno_regwr  = regwr_reg;
  assign zxuno_wrdata = wrdata_reg;
  assign dout         = dout_reg;
  assign oe_n         = oe_n_reg;

endmodule
